// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (CPU = m0, DMA = m1) round-robin arbiter in front of one slave.
// Optional slave-ready timeout and sticky o_timeout flag when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_m0_request,
    input  logic        i_m0_rw,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_wdata,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_ready,
    input  logic        i_m1_request,
    input  logic        i_m1_rw,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_ready,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic [1:0]  o_grant
`ifdef BUS_ARBITER_TIMEOUT_EN
    ,
    output logic        o_timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic        last_grant_r, last_grant_s;
    logic        owner_r, owner_s;
    logic        bus_request_r, bus_request_s;
    logic        bus_rw_r, bus_rw_s;
    logic [31:0] bus_address_r, bus_address_s;
    logic [31:0] bus_wdata_r, bus_wdata_s;
    logic [31:0] m0_rdata_r, m0_rdata_s;
    logic [31:0] m1_rdata_r, m1_rdata_s;
    logic        m0_ready_r, m0_ready_s;
    logic        m1_ready_r, m1_ready_s;
    logic [1:0]  grant_r, grant_s;
    logic        pick_s;
    logic        owner_req_s;
    logic        done_s;
    logic [31:0] done_rdata_s;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] cnt_r, cnt_s;
    logic            timeout_r, timeout_s;
    assign o_timeout = timeout_r;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    assign o_bus_request = bus_request_r;
    assign o_bus_rw      = bus_rw_r;
    assign o_bus_address = bus_address_r;
    assign o_bus_wdata   = bus_wdata_r;
    assign o_m0_rdata    = m0_rdata_r;
    assign o_m1_rdata    = m1_rdata_r;
    assign o_m0_ready    = m0_ready_r;
    assign o_m1_ready    = m1_ready_r;
    assign o_grant       = grant_r;

    // Register bank: every state element loads its precomputed next value.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r       <= IDLE;
            last_grant_r  <= 1'b1;
            owner_r       <= 1'b0;
            bus_request_r <= 1'b0;
            bus_rw_r      <= 1'b0;
            bus_address_r <= 32'h0000_0000;
            bus_wdata_r   <= 32'h0000_0000;
            m0_rdata_r    <= 32'h0000_0000;
            m1_rdata_r    <= 32'h0000_0000;
            m0_ready_r    <= 1'b0;
            m1_ready_r    <= 1'b0;
            grant_r       <= 2'b00;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_r         <= '0;
            timeout_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            last_grant_r  <= last_grant_s;
            owner_r       <= owner_s;
            bus_request_r <= bus_request_s;
            bus_rw_r      <= bus_rw_s;
            bus_address_r <= bus_address_s;
            bus_wdata_r   <= bus_wdata_s;
            m0_rdata_r    <= m0_rdata_s;
            m1_rdata_r    <= m1_rdata_s;
            m0_ready_r    <= m0_ready_s;
            m1_ready_r    <= m1_ready_s;
            grant_r       <= grant_s;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_r         <= cnt_s;
            timeout_r     <= timeout_s;
`endif
        end
    end

    // Next-state and next-output logic for the IDLE / BUSY / RELEASE sequence.
    always_comb begin
        state_s       = state_r;
        last_grant_s  = last_grant_r;
        owner_s       = owner_r;
        bus_request_s = bus_request_r;
        bus_rw_s      = bus_rw_r;
        bus_address_s = bus_address_r;
        bus_wdata_s   = bus_wdata_r;
        m0_rdata_s    = m0_rdata_r;
        m1_rdata_s    = m1_rdata_r;
        m0_ready_s    = 1'b0;
        m1_ready_s    = 1'b0;
        grant_s       = grant_r;
        done_s        = 1'b0;
        done_rdata_s  = i_bus_rdata;
`ifdef BUS_ARBITER_TIMEOUT_EN
        cnt_s         = cnt_r;
        timeout_s     = timeout_r;
`endif
        owner_req_s = owner_r ? i_m1_request : i_m0_request;

        // On a tie the master that did not win last time gets the bus.
        if (i_m0_request && i_m1_request) begin
            pick_s = ~last_grant_r;
        end else if (i_m1_request) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end

        case (state_r)
            IDLE: begin
                if (i_m0_request || i_m1_request) begin
                    state_s       = BUSY;
                    last_grant_s  = pick_s;
                    owner_s       = pick_s;
                    bus_request_s = 1'b1;
                    grant_s       = pick_s ? 2'b10 : 2'b01;
                    if (pick_s) begin
                        bus_rw_s      = i_m1_rw;
                        bus_address_s = i_m1_address;
                        bus_wdata_s   = i_m1_wdata;
                    end else begin
                        bus_rw_s      = i_m0_rw;
                        bus_address_s = i_m0_address;
                        bus_wdata_s   = i_m0_wdata;
                    end
`ifdef BUS_ARBITER_TIMEOUT_EN
                    cnt_s = '0;
`endif
                end else begin
                    grant_s = 2'b00;
                end
            end
            BUSY: begin
                if (i_bus_ready) begin
                    done_s = 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
                end else if (cnt_r == TO_W'(TIMEOUT)) begin
                    done_s       = 1'b1;
                    done_rdata_s = 32'h0000_0000;
                    timeout_s    = 1'b1;
                end else begin
                    cnt_s = cnt_r + TO_W'(1);
`else
                end else begin
                    done_s = 1'b0;
`endif
                end
                // A master that abandoned its request mid-transfer gets no ready.
                if (done_s) begin
                    bus_request_s = 1'b0;
                    state_s       = RELEASE;
                    if (owner_r) begin
                        m1_rdata_s = done_rdata_s;
                        m1_ready_s = i_m1_request;
                    end else begin
                        m0_rdata_s = done_rdata_s;
                        m0_ready_s = i_m0_request;
                    end
                end else begin
                    bus_request_s = 1'b1;
                end
            end
            RELEASE: begin
                if (owner_r) begin
                    m1_ready_s = m1_ready_r & i_m1_request;
                end else begin
                    m0_ready_s = m0_ready_r & i_m0_request;
                end
                if (!owner_req_s && !i_bus_ready) begin
                    state_s = IDLE;
                    grant_s = 2'b00;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                state_s       = IDLE;
                grant_s       = 2'b00;
                bus_request_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: one task per scenario with inline checks.
// Define BUS_ARBITER_TIMEOUT_EN to build and exercise the timeout variant (TIMEOUT = 8).
module tb_bus_arbiter;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_m0_request = 1'b0, i_m0_rw = 1'b0;
    logic [31:0] i_m0_address = 32'h0, i_m0_wdata = 32'h0;
    logic        i_m1_request = 1'b0, i_m1_rw = 1'b0;
    logic [31:0] i_m1_address = 32'h0, i_m1_wdata = 32'h0;
    logic        i_bus_ready = 1'b0;
    logic [31:0] i_bus_rdata = 32'h0;
    logic [31:0] o_m0_rdata, o_m1_rdata, o_bus_address, o_bus_wdata;
    logic        o_m0_ready, o_m1_ready, o_bus_request, o_bus_rw;
    logic [1:0]  o_grant;
`ifdef BUS_ARBITER_TIMEOUT_EN
    logic        o_timeout;
`endif

    int errors = 0;
    int checks = 0;

    bus_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_m0_request(i_m0_request), .i_m0_rw(i_m0_rw), .i_m0_address(i_m0_address),
        .i_m0_wdata(i_m0_wdata), .o_m0_rdata(o_m0_rdata), .o_m0_ready(o_m0_ready),
        .i_m1_request(i_m1_request), .i_m1_rw(i_m1_rw), .i_m1_address(i_m1_address),
        .i_m1_wdata(i_m1_wdata), .o_m1_rdata(o_m1_rdata), .o_m1_ready(o_m1_ready),
        .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
        .o_bus_wdata(o_bus_wdata), .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
        .o_grant(o_grant)
`ifdef BUS_ARBITER_TIMEOUT_EN
        , .o_timeout(o_timeout)
`endif
    );

    always #5 i_clock = ~i_clock;

    // Slave model: answers one cycle after seeing a request; logs every accepted beat.
    logic        slave_en = 1'b0;
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic        log_rw[$];
    logic [1:0]  log_grant[$];
    logic [1:0]  grant_hist[$];
    logic [1:0]  prev_grant = 2'b00;

    function automatic logic [31:0] slave_rdata(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'hCAFE_BABE;
        else return a ^ 32'h5A5A_0000;
    endfunction

    always @(negedge i_clock) begin
        if (slave_en && o_bus_request && !i_bus_ready) begin
            i_bus_ready = 1'b1;
            i_bus_rdata = slave_rdata(o_bus_address);
            log_addr.push_back(o_bus_address);
            log_wdata.push_back(o_bus_wdata);
            log_rw.push_back(o_bus_rw);
            log_grant.push_back(o_grant);
        end else begin
            i_bus_ready = 1'b0;
            i_bus_rdata = 32'hDEAD_0000;
        end
        if (o_grant != 2'b00 && o_grant != prev_grant) grant_hist.push_back(o_grant);
        prev_grant = o_grant;
    end

    task automatic master_xfer(input int m, input logic rw, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic ok);
        ok = 1'b0;
        rdata = 32'h0;
        if (m == 0) begin
            i_m0_rw = rw; i_m0_address = addr; i_m0_wdata = wdata; i_m0_request = 1'b1;
        end else begin
            i_m1_rw = rw; i_m1_address = addr; i_m1_wdata = wdata; i_m1_request = 1'b1;
        end
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge i_clock);
            if (m == 0 && o_m0_ready) begin
                ok = 1'b1; rdata = o_m0_rdata;
            end else if (m == 1 && o_m1_ready) begin
                ok = 1'b1; rdata = o_m1_rdata;
            end
        end
        if (m == 0) i_m0_request = 1'b0;
        else i_m1_request = 1'b0;
        @(negedge i_clock);
    endtask

    task automatic clear_logs();
        log_addr.delete(); log_wdata.delete(); log_rw.delete(); log_grant.delete();
        grant_hist.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_m0_request = 1'b0;
        i_m1_request = 1'b0;
        repeat (2) @(negedge i_clock);
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", o_grant); end
        checks++; if (o_bus_request !== 1'b0) begin errors++; $display("FAIL reset_bus_request: got %b expected 0", o_bus_request); end
        checks++; if ({o_m0_ready, o_m1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {o_m0_ready, o_m1_ready}); end
        checks++; if ({o_m0_rdata, o_m1_rdata, o_bus_address, o_bus_wdata} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {o_m0_rdata, o_m1_rdata, o_bus_address, o_bus_wdata}); end
        i_reset = 1'b0;
        @(negedge i_clock);
    endtask

    task automatic test_m0_write();
        slave_en = 1'b1;
        i_m0_rw = 1'b1; i_m0_address = 32'h0000_0100; i_m0_wdata = 32'h1234_5678;
        i_m0_request = 1'b1;
        @(negedge i_clock);
        checks++; if (o_bus_request !== 1'b1) begin errors++; $display("FAIL m0w_bus_request: got %b expected 1", o_bus_request); end
        checks++; if (o_bus_address !== 32'h0000_0100 || o_bus_wdata !== 32'h1234_5678 || o_bus_rw !== 1'b1) begin errors++; $display("FAIL m0w_bus_fields: got %h/%h/%b expected 00000100/12345678/1", o_bus_address, o_bus_wdata, o_bus_rw); end
        checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL m0w_grant: got %b expected 01", o_grant); end
        @(negedge i_clock);
        checks++; if (o_m0_ready !== 1'b1 || o_m1_ready !== 1'b0) begin errors++; $display("FAIL m0w_ready: got %b%b expected 10", o_m0_ready, o_m1_ready); end
        checks++; if (o_bus_request !== 1'b0) begin errors++; $display("FAIL m0w_bus_drop: got %b expected 0", o_bus_request); end
        checks++; if (o_m0_rdata !== 32'h5A5A_0100) begin errors++; $display("FAIL m0w_rdata_latched: got %h expected 5a5a0100", o_m0_rdata); end
        i_m0_request = 1'b0;
        @(negedge i_clock);
        checks++; if (o_m0_ready !== 1'b0 || o_grant !== 2'b00) begin errors++; $display("FAIL m0w_release: got ready=%b grant=%b expected 0/00", o_m0_ready, o_grant); end
    endtask

    task automatic test_m1_read();
        logic [31:0] rd;
        logic        ok;
        clear_logs();
        master_xfer(1, 1'b0, 32'h0000_0200, 32'h0, rd, ok);
        checks++; if (!ok || rd !== 32'hCAFE_BABE) begin errors++; $display("FAIL m1r_rdata: got ok=%b %h expected 1 cafebabe", ok, rd); end
        checks++; if (grant_hist.size() != 1 || grant_hist[0] !== 2'b10) begin errors++; $display("FAIL m1r_grant: got %0d grants first=%b expected 1 grant 10", grant_hist.size(), (grant_hist.size() > 0) ? grant_hist[0] : 2'bxx); end
        checks++; if (o_m0_rdata !== 32'h5A5A_0100) begin errors++; $display("FAIL m1r_m0_rdata_kept: got %h expected 5a5a0100", o_m0_rdata); end
    endtask

    task automatic test_both_same_cycle();
        test_reset();
        clear_logs();
        fork
            begin
                logic [31:0] rd_a; logic ok_a;
                master_xfer(0, 1'b1, 32'h0000_0300, 32'h0000_0011, rd_a, ok_a);
                checks++; if (!ok_a) begin errors++; $display("FAIL both_m0_done: got ok=%b expected 1", ok_a); end
            end
            begin
                logic [31:0] rd_b; logic ok_b;
                master_xfer(1, 1'b1, 32'h0000_0400, 32'h0000_0022, rd_b, ok_b);
                checks++; if (!ok_b) begin errors++; $display("FAIL both_m1_done: got ok=%b expected 1", ok_b); end
            end
        join
        checks++; if (log_addr.size() != 2 || log_addr[0] !== 32'h0000_0300 || log_addr[1] !== 32'h0000_0400) begin errors++; $display("FAIL both_order: got %0d beats expected 0x300 then 0x400", log_addr.size()); end
        clear_logs();
        fork
            for (int k = 0; k < 3; k++) begin
                logic [31:0] rd_c; logic ok_c;
                master_xfer(0, 1'b1, 32'h0000_0600 + 32'(k * 4), 32'h0, rd_c, ok_c);
            end
            for (int j = 0; j < 3; j++) begin
                logic [31:0] rd_d; logic ok_d;
                master_xfer(1, 1'b1, 32'h0000_0700 + 32'(j * 4), 32'h0, rd_d, ok_d);
            end
        join
        checks++; if (grant_hist.size() != 6) begin errors++; $display("FAIL alt_count: got %0d grants expected 6", grant_hist.size()); end
        for (int i = 0; i < grant_hist.size(); i++) begin
            checks++; if (grant_hist[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_grant[%0d]: got %b expected %b", i, grant_hist[i], (i % 2 == 0) ? 2'b01 : 2'b10); end
        end
    endtask

    task automatic test_dma_copy();
        int n1;
        clear_logs();
        fork
            for (int k = 0; k < 4; k++) begin
                logic [31:0] rd_e; logic ok_e;
                master_xfer(1, 1'b1, 32'h0000_1000 + 32'(k * 4), 32'hD000_0000 + 32'(k), rd_e, ok_e);
            end
            for (int j = 0; j < 4; j++) begin
                logic [31:0] rd_f; logic ok_f;
                master_xfer(0, 1'b0, 32'h0000_2000 + 32'(j * 4), 32'h0, rd_f, ok_f);
            end
        join
        n1 = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_grant[i] == 2'b10) begin
                checks++; if (log_addr[i] !== 32'h0000_1000 + 32'(n1 * 4) || log_wdata[i] !== 32'hD000_0000 + 32'(n1) || log_rw[i] !== 1'b1) begin errors++; $display("FAIL dma_beat[%0d]: got %h/%h expected %h/%h", n1, log_addr[i], log_wdata[i], 32'h0000_1000 + 32'(n1 * 4), 32'hD000_0000 + 32'(n1)); end
                n1++;
            end
        end
        checks++; if (n1 != 4) begin errors++; $display("FAIL dma_beats: got %0d expected 4", n1); end
        checks++; if (grant_hist.size() != 8) begin errors++; $display("FAIL dma_interleave_count: got %0d expected 8", grant_hist.size()); end
        for (int i = 0; i < grant_hist.size(); i++) begin
            checks++; if (grant_hist[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL dma_interleave[%0d]: got %b expected %b", i, grant_hist[i], (i % 2 == 0) ? 2'b01 : 2'b10); end
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd;
        logic        ok;
        slave_en = 1'b0;
        i_m0_rw = 1'b0; i_m0_address = 32'h0000_0700; i_m0_request = 1'b1;
        repeat (2) @(negedge i_clock);
        checks++; if (o_bus_request !== 1'b1 || o_grant !== 2'b01) begin errors++; $display("FAIL rb_busy: got req=%b grant=%b expected 1/01", o_bus_request, o_grant); end
        i_reset = 1'b1;
        @(negedge i_clock);
        checks++; if (o_bus_request !== 1'b0 || o_grant !== 2'b00 || o_m0_ready !== 1'b0 || o_m0_rdata !== 32'h0) begin errors++; $display("FAIL rb_cleared: got req=%b grant=%b rdy=%b rdata=%h expected 0/00/0/0", o_bus_request, o_grant, o_m0_ready, o_m0_rdata); end
        i_reset = 1'b0;
        i_m0_request = 1'b0;
        @(negedge i_clock);
        slave_en = 1'b1;
        master_xfer(0, 1'b0, 32'h0000_0500, 32'h0, rd, ok);
        checks++; if (!ok || rd !== 32'h5A5A_0500) begin errors++; $display("FAIL rb_after: got ok=%b %h expected 1 5a5a0500", ok, rd); end
    endtask

    task automatic test_drop_in_busy();
        logic seen;
        slave_en = 1'b0;
        i_m0_rw = 1'b1; i_m0_address = 32'h0000_0800; i_m0_request = 1'b1;
        repeat (2) @(negedge i_clock);
        i_m0_request = 1'b0;
        slave_en = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge i_clock);
            if (o_m0_ready) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL drop_no_ready: got %b expected 0", seen); end
        checks++; if (o_grant !== 2'b00 || o_bus_request !== 1'b0) begin errors++; $display("FAIL drop_exit: got grant=%b req=%b expected 00/0", o_grant, o_bus_request); end
    endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd;
        logic        ok;
        slave_en = 1'b0;
        i_m0_rw = 1'b0; i_m0_address = 32'h0000_0900; i_m0_request = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge i_clock);
            if (n == 9) begin
                checks++; if (o_m0_ready !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got rdy=%b to=%b expected 0/0", o_m0_ready, o_timeout); end
            end
            if (n == 10) begin
                checks++; if (o_m0_ready !== 1'b1 || o_m0_rdata !== 32'h0 || o_timeout !== 1'b1) begin errors++; $display("FAIL to_fire: got rdy=%b rdata=%h to=%b expected 1/0/1", o_m0_ready, o_m0_rdata, o_timeout); end
            end
        end
        i_m0_request = 1'b0;
        repeat (2) @(negedge i_clock);
        slave_en = 1'b1;
        master_xfer(0, 1'b0, 32'h0000_0500, 32'h0, rd, ok);
        checks++; if (!ok || o_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got ok=%b to=%b expected 1/1", ok, o_timeout); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_m0_write();
        test_m1_read();
        test_both_same_cycle();
        test_dma_copy();
        test_reset_busy();
        test_drop_in_busy();
`ifdef BUS_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
